spi_shift_engine: RTL and testbench

//  SPI master shift engine directly downstream of the baud rate divider.
//  - Consumes the divider's toggling Nout as baud_in; each baud_in transition is one SCK half-period tick.
//  - Serialises words from a TX FIFO onto mosi/sclk and controls cs_n.
//  - Deserialises miso into an RX FIFO. Supports CPOL/CPHA modes 0-3, MSB first, 1..MAX_BITS bits per word.

---
 rtl/spi_shift_engine.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_spi_shift_engine.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
// SPI master shift engine fed by the baud divider's toggling output.
// Ports: SOURCE_CLK/reset (sync, active-high); enable freezes the engine;
//   baud_in is the divider output (each transition = one SCK half-period);
//   cpol/cpha/word_len configure the next word; tx_data/tx_valid/tx_ready
//   feed the TX FIFO; rx_data/rx_valid/rx_ready drain the RX FIFO;
//   sclk/mosi/miso/cs_n are the SPI pins; busy = not idle;
//   rx_overflow is a sticky flag set when a received word is dropped.
module spi_shift_engine #(
  parameter int MAX_BITS   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                SOURCE_CLK,
  input  logic                reset,
  input  logic                enable,
  input  logic                baud_in,
  input  logic                cpol,
  input  logic                cpha,
  input  logic [4:0]          word_len,
  input  logic [MAX_BITS-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [MAX_BITS-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output logic                cs_n,
  output logic                busy,
  output logic                rx_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = 6;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  // ---------------------------------------------------------------
  // Tick generation: 2-flop synchroniser plus one compare stage
  // ---------------------------------------------------------------
  logic [2:0] baud_sr;
  logic       tick;

  always_ff @(posedge SOURCE_CLK) begin
    if (reset) begin
      baud_sr <= '0;
    end else begin
      baud_sr <= {baud_sr[1:0], baud_in};
    end
  end

  assign tick = (baud_sr[2] ^ baud_sr[1]) & enable;

  // ---------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------
  logic [MAX_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]       tx_wr;
  logic [AW-1:0]       tx_rd;
  logic [CW-1:0]       tx_cnt;
  logic                tx_push;
  logic                tx_pop;
  logic                tx_empty;
  logic [MAX_BITS-1:0] tx_head;

  assign tx_ready = (tx_cnt != CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign tx_push  = tx_valid & tx_ready;
  assign tx_head  = tx_mem[tx_rd];

  always_ff @(posedge SOURCE_CLK) begin
    if (tx_push) begin
      tx_mem[tx_wr] <= tx_data;
    end
  end

  always_ff @(posedge SOURCE_CLK) begin
    if (reset) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) begin
        tx_wr <= tx_wr + 1'b1;
      end
      if (tx_pop) begin
        tx_rd <= tx_rd + 1'b1;
      end
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
    end
  end

  // ---------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------
  logic [MAX_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]       rx_wr;
  logic [AW-1:0]       rx_rd;
  logic [CW-1:0]       rx_cnt;
  logic                rx_push;
  logic                rx_full;
  logic                rx_wen;
  logic                rx_pop;
  logic [MAX_BITS-1:0] rx_word;
  logic                ovf_q;

  assign rx_full     = (rx_cnt == CW'(FIFO_DEPTH));
  assign rx_valid    = (rx_cnt != '0);
  assign rx_pop      = rx_valid & rx_ready;
  assign rx_wen      = rx_push & ~rx_full;
  assign rx_data     = rx_valid ? rx_mem[rx_rd] : '0;
  assign rx_overflow = ovf_q;

  always_ff @(posedge SOURCE_CLK) begin
    if (rx_wen) begin
      rx_mem[rx_wr] <= rx_word;
    end
  end

  always_ff @(posedge SOURCE_CLK) begin
    if (reset) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (rx_wen) begin
        rx_wr <= rx_wr + 1'b1;
      end
      if (rx_pop) begin
        rx_rd <= rx_rd + 1'b1;
      end
      rx_cnt <= rx_cnt + CW'(rx_wen) - CW'(rx_pop);
      // a full FIFO drops the new word, even if a pop happens this cycle
      if (rx_push && rx_full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Shift FSM
  // ---------------------------------------------------------------
  state_t              state_q;
  state_t              state_d;
  logic                sclk_q;
  logic                sclk_d;
  logic                mosi_q;
  logic                mosi_d;
  logic                cs_q;
  logic                cs_d;
  logic [MAX_BITS-1:0] tx_sh_q;
  logic [MAX_BITS-1:0] tx_sh_d;
  logic [MAX_BITS-1:0] rx_sh_q;
  logic [MAX_BITS-1:0] rx_sh_d;
  logic [MAX_BITS-1:0] rx_nx;
  logic [4:0]          len_q;
  logic [4:0]          len_d;
  logic [4:0]          wl_eff;
  logic                cpha_q;
  logic                cpha_d;
  logic [TW-1:0]       cnt_q;
  logic [TW-1:0]       cnt_d;
  logic [TW-1:0]       cnt_nx;
  logic                lead;
  logic                smp;
  logic                last;
  logic                load;

  function automatic logic msb_of(
    input logic [MAX_BITS-1:0] w,
    input logic [4:0]          len
  );
    logic [MAX_BITS-1:0] s;
    s = w >> (len - 5'd1);
    return s[0];
  endfunction

  assign wl_eff = ((word_len == 5'd0) || (word_len > 5'(MAX_BITS)))
                ? 5'(MAX_BITS) : word_len;

  always_comb begin
    state_d = state_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    len_d   = len_q;
    cpha_d  = cpha_q;
    cnt_d   = cnt_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    load    = 1'b0;
    cnt_nx  = cnt_q + 1'b1;
    // odd tick numbers are leading edges
    lead    = cnt_nx[0];
    smp     = lead ^ cpha_q;
    last    = (cnt_nx == {len_q, 1'b0});
    rx_nx   = smp ? {rx_sh_q[MAX_BITS-2:0], miso} : rx_sh_q;
    rx_word = rx_nx;

    unique case (state_q)
      IDLE: begin
        sclk_d = cpol;
        cs_d   = 1'b1;
        if (enable && !tx_empty) begin
          load    = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          cnt_d   = cnt_nx;
          sclk_d  = ~sclk_q;
          rx_sh_d = rx_nx;
          // the edge after the final sample needs no new data bit
          if (!smp && !last) begin
            mosi_d  = msb_of(tx_sh_q, len_q);
            tx_sh_d = tx_sh_q << 1;
          end
          if (last) begin
            rx_push = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (!tx_empty) begin
            load    = 1'b1;
            state_d = SHIFT;
          end else begin
            cs_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      tx_pop  = 1'b1;
      len_d   = wl_eff;
      cpha_d  = cpha;
      sclk_d  = cpol;
      cs_d    = 1'b0;
      cnt_d   = '0;
      rx_sh_d = '0;
      mosi_d  = msb_of(tx_head, wl_eff);
      // cpha=1 re-drives the MSB on the first leading edge
      tx_sh_d = cpha ? tx_head : (tx_head << 1);
    end
  end

  always_ff @(posedge SOURCE_CLK) begin
    if (reset) begin
      state_q <= IDLE;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      len_q   <= 5'(MAX_BITS);
      cpha_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      len_q   <= len_d;
      cpha_q  <= cpha_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign cs_n = cs_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine.
// Randomised words/modes checked against a word-level SPI model.
module tb_spi_shift_engine;

  logic        SOURCE_CLK = 1'b0;
  logic        reset;
  logic        enable;
  logic        baud_in;
  logic        cpol;
  logic        cpha;
  logic [4:0]  word_len;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        cs_n;
  logic        busy;
  logic        rx_overflow;

  int          mmode;
  int          tests = 0;
  int          fails = 0;

  logic        mosi_bits[$];
  int          fr_edges[$];
  int          fr_cycles[$];
  logic [15:0] rx_got[$];
  logic [15:0] wq[$];
  int          cur_edges;
  int          cur_cycles;
  logic        prev_sclk;
  logic        prev_cs;
  logic        rdy5;

  spi_shift_engine dut (
    .SOURCE_CLK (SOURCE_CLK),
    .reset      (reset),
    .enable     (enable),
    .baud_in    (baud_in),
    .cpol       (cpol),
    .cpha       (cpha),
    .word_len   (word_len),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .cs_n       (cs_n),
    .busy       (busy),
    .rx_overflow(rx_overflow)
  );

  // slave: 0 = loopback, 1 = constant one, 2 = inverted loopback
  assign miso = (mmode == 0) ? mosi : (mmode == 1) ? 1'b1 : ~mosi;

  always #5 SOURCE_CLK = ~SOURCE_CLK;

  initial begin
    baud_in = 1'b0;
    forever #30 baud_in = ~baud_in;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // pin monitor: frames, sample-edge mosi bits, rx words taken
  initial begin
    prev_sclk  = 1'b0;
    prev_cs    = 1'b1;
    cur_edges  = 0;
    cur_cycles = 0;
    forever begin
      @(negedge SOURCE_CLK);
      if (cs_n === 1'b0) begin
        cur_cycles++;
        if (sclk !== prev_sclk) begin
          cur_edges++;
          if ((prev_sclk == cpol) != cpha) mosi_bits.push_back(mosi);
        end
      end
      if (cs_n === 1'b1 && prev_cs === 1'b0) begin
        fr_edges.push_back(cur_edges);
        fr_cycles.push_back(cur_cycles);
      end
      if (cs_n === 1'b1) begin
        cur_edges  = 0;
        cur_cycles = 0;
      end
      if (rx_valid && rx_ready) rx_got.push_back(rx_data);
      prev_sclk = sclk;
      prev_cs   = cs_n;
    end
  end

  task automatic push(input logic [15:0] d);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 5000) begin
      @(posedge SOURCE_CLK); #1;
      n++;
    end
    if (n >= 5000) check("push_timeout", tx_ready, 1);
    @(posedge SOURCE_CLK); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (3) @(posedge SOURCE_CLK);
    while (busy && n < 5000) begin
      @(posedge SOURCE_CLK);
      n++;
    end
    #1;
    check({tag, "_done"}, busy, 0);
  endtask

  task automatic run_burst(input string tag, input logic p, input logic h,
                           input logic [4:0] wl, input int mm,
                           input int freeze_at);
    int          le;
    int          nw;
    int          n;
    int          lo;
    logic [15:0] mask;
    logic [15:0] e;
    logic [15:0] m;
    logic        s0;
    logic        m0;
    logic        ok;
    nw       = wq.size();
    cpol     = p;
    cpha     = h;
    word_len = wl;
    mmode    = mm;
    repeat (4) @(posedge SOURCE_CLK); #1;
    check({tag, "_idle_sclk"}, sclk, p);
    mosi_bits.delete();
    fr_edges.delete();
    fr_cycles.delete();
    rx_got.delete();
    le   = (wl == 0 || wl > 16) ? 16 : int'(wl);
    mask = 16'((32'h1 << le) - 1);
    for (int i = 0; i < nw; i++) begin
      push(wq[i]);
      if (i == 4) rdy5 = tx_ready;
    end
    if (freeze_at > 0) begin
      n = 0;
      while (cur_edges < freeze_at && n < 5000) begin
        @(posedge SOURCE_CLK);
        n++;
      end
      #1;
      enable = 1'b0;
      @(posedge SOURCE_CLK); #1;
      s0 = sclk;
      m0 = mosi;
      ok = 1'b1;
      repeat (33) begin
        @(posedge SOURCE_CLK); #1;
        if (sclk !== s0 || mosi !== m0 || busy !== 1'b1) ok = 1'b0;
      end
      check({tag, "_frozen"}, ok, 1);
      enable = 1'b1;
    end
    wait_idle(tag);
    repeat (4) @(posedge SOURCE_CLK); #1;
    check({tag, "_nrx"}, rx_got.size(), nw);
    for (int i = 0; i < nw && i < rx_got.size(); i++) begin
      e = (mm == 0) ? (wq[i] & mask) : (mm == 1) ? mask : (~wq[i] & mask);
      check($sformatf("%s_rx%0d", tag, i), rx_got[i], e);
    end
    check({tag, "_nbits"}, mosi_bits.size(), nw * le);
    for (int i = 0; i < nw && (i + 1) * le <= mosi_bits.size(); i++) begin
      m = '0;
      for (int b = 0; b < le; b++) m = {m[14:0], mosi_bits[i * le + b]};
      check($sformatf("%s_mosi%0d", tag, i), m, wq[i] & mask);
    end
    check({tag, "_frames"}, fr_edges.size(), 1);
    if (fr_edges.size() > 0) begin
      check({tag, "_edges"}, fr_edges[0], 2 * le * nw);
      if (freeze_at == 0) begin
        lo = 1 + 3 * (nw * (2 * le + 1));
        check({tag, "_csdur"},
              (fr_cycles[0] >= lo && fr_cycles[0] <= lo + 2), 1);
      end
    end
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    enable   = 1'b1;
    cpol     = 1'b0;
    cpha     = 1'b0;
    word_len = 5'd8;
    tx_data  = '0;
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    mmode    = 0;
    rdy5     = 1'b1;
    repeat (3) @(posedge SOURCE_CLK); #1;
    reset = 1'b0;
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_busy", busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_ovf", rx_overflow, 0);
    check("rst_tx_ready", tx_ready, 1);

    // T1: mode 0, 8-bit loopback
    wq = {16'h00A5};
    run_burst("t1", 1'b0, 1'b0, 5'd8, 0, 0);

    // T2: mode 3, 16-bit, miso high
    wq = {16'h1234};
    run_burst("t2", 1'b1, 1'b1, 5'd16, 1, 0);
    check("t2_ovf", rx_overflow, 0);

    // T3: six back-to-back words, mode 1; TX fills after the fifth push
    wq.delete();
    for (int i = 0; i < 6; i++) wq.push_back(16'($urandom));
    rdy5 = 1'b1;
    run_burst("t3", 1'b0, 1'b1, 5'd4, 0, 0);
    check("t3_full", rdy5, 0);
    check("t3_ready_after", tx_ready, 1);

    // T4: RX never drained during five words
    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back(16'($urandom));
    cpol     = 1'b0;
    cpha     = 1'b0;
    word_len = 5'd4;
    mmode    = 0;
    rx_ready = 1'b0;
    repeat (3) @(posedge SOURCE_CLK); #1;
    rx_got.delete();
    for (int i = 0; i < 5; i++) push(wq[i]);
    wait_idle("t4");
    repeat (4) @(posedge SOURCE_CLK); #1;
    check("t4_ovf", rx_overflow, 1);
    check("t4_valid", rx_valid, 1);
    check("t4_taken", rx_got.size(), 0);
    rx_ready = 1'b1;
    repeat (8) @(posedge SOURCE_CLK); #1;
    check("t4_ndrain", rx_got.size(), 4);
    for (int i = 0; i < 4 && i < rx_got.size(); i++)
      check($sformatf("t4_rx%0d", i), rx_got[i], wq[i] & 16'h000F);
    check("t4_empty", rx_valid, 0);

    // T5: reset three bits into a word with another word queued
    cpol     = 1'b0;
    cpha     = 1'b0;
    word_len = 5'd8;
    repeat (3) @(posedge SOURCE_CLK); #1;
    rx_got.delete();
    push(16'h005A);
    push(16'h00C3);
    n = 0;
    while (cur_edges < 6 && n < 5000) begin
      @(posedge SOURCE_CLK);
      n++;
    end
    #1;
    reset = 1'b1;
    @(posedge SOURCE_CLK); #1;
    reset = 1'b0;
    check("t5_cs_n", cs_n, 1);
    check("t5_busy", busy, 0);
    check("t5_tx_ready", tx_ready, 1);
    check("t5_rx_valid", rx_valid, 0);
    check("t5_sclk", sclk, 0);
    check("t5_ovf", rx_overflow, 0);
    repeat (80) @(posedge SOURCE_CLK); #1;
    check("t5_no_rx", rx_got.size(), 0);
    check("t5_stay_idle", busy, 0);

    // T6: word_len 0 (16 bits) with a freeze mid-word
    wq = {16'($urandom)};
    run_burst("t6", 1'b0, 1'b0, 5'd0, 0, 7);

    // randomised bursts
    for (int k = 0; k < 10; k++) begin
      wq.delete();
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
      run_burst($sformatf("r%0d", k), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 20)),
                $urandom_range(0, 2), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
